// File: rtl/layer_pkg.sv
// Shared widths and the writer state encoding for the layer output-buffer writers.
package layer_pkg;

    localparam int ACC_W  = 32;
    localparam int ACT_W  = 8;
    localparam int BUF_AW = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } wr_state_e;

endpackage

// File: rtl/quant_relu_sat.sv
// ReLU, right-shift requantisation and saturation of one signed accumulator.
// Define L4W_ROUND_EN to round half up before the shift instead of truncating.
module quant_relu_sat
    import layer_pkg::*;
#(
    parameter int SHIFT   = 7,
    parameter int OUT_MAX = 127
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [ACT_W-1:0] act
);

    localparam logic [ACC_W:0] SAT = (ACC_W+1)'(OUT_MAX);
`ifdef L4W_ROUND_EN
    localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT - 1);
`endif

    // One spare bit keeps the rounding add from wrapping, so an overflowing
    // sum lands in the saturation branch instead of going negative.
    logic [ACC_W:0] biased;
    logic [ACC_W:0] scaled;

    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to hold the old one.
    always_comb begin
        biased = {1'b0, acc};
`ifdef L4W_ROUND_EN
        biased = biased + HALF;
`endif
        scaled = biased >> SHIFT;
        if (acc[ACC_W-1]) begin
            act = '0;
        end else if (scaled > SAT) begin
            act = SAT[ACT_W-1:0];
        end else begin
            act = scaled[ACT_W-1:0];
        end
    end

endmodule

// File: rtl/layer4_obuf_writer.sv
// Layer-4 activation buffer writer: quantises LANES accumulators per handshake and
// serialises them into single-port buffer writes. Rounding mode set by L4W_ROUND_EN.
module layer4_obuf_writer
    import layer_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int DEPTH   = 32,
    parameter int SHIFT   = 7,
    parameter int OUT_MAX = 127
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    start_i,
    input  logic                    acc_valid_i,
    output logic                    acc_ready_o,
    input  logic [LANES*ACC_W-1:0]  acc_data_i,
    output logic                    buf_en_o,
    output logic                    buf_wen_o,
    output logic [BUF_AW-1:0]       buf_addr_o,
    output logic [ACT_W-1:0]        buf_din_o,
    output logic                    frame_done_o,
    output logic                    busy_o
);

    localparam int                LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [BUF_AW-1:0] LAST_ADDR = BUF_AW'(DEPTH - 1);

    wr_state_e         state_q, state_d;
    logic [BUF_AW-1:0] addr_q, addr_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [ACT_W-1:0]  act_lane [LANES];
    logic [ACT_W-1:0]  act_q    [LANES];
    logic              accept;
    logic              drain;

    // Quantise on the way in so only ACT_W bits per lane are held during DRAIN.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        quant_relu_sat #(
            .SHIFT   (SHIFT),
            .OUT_MAX (OUT_MAX)
        ) u_quant (
            .acc (acc_data_i[l*ACC_W +: ACC_W]),
            .act (act_lane[l])
        );
    end

    // start_i outranks a simultaneous bundle, so the handshake is masked by it.
    assign accept = (state_q == ACCEPT) && acc_valid_i && !start_i;
    assign drain  = (state_q == DRAIN);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lane_d  = lane_q;
        case (state_q)
            IDLE: ;
            ACCEPT: begin
                if (accept) begin
                    state_d = DRAIN;
                    lane_d  = '0;
                end
            end
            DRAIN: begin
                addr_d = addr_q + 1'b1;
                lane_d = lane_q + 1'b1;
                if (lane_q == LAST_LANE) begin
                    lane_d  = '0;
                    state_d = (addr_q == LAST_ADDR) ? DONE : ACCEPT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (start_i) begin
            state_d = ACCEPT;
            addr_d  = '0;
            lane_d  = '0;
        end
    end

    // NOTE: registers use non-blocking assignment so every flop samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lane_q  <= lane_d;
        end
    end

    // NOTE: the lane holding registers carry no reset; they are only read in
    // DRAIN, which is always preceded by a capture.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            act_q <= act_lane;
        end
    end

    assign acc_ready_o  = (state_q == ACCEPT);
    assign busy_o       = (state_q != IDLE);
    assign buf_en_o     = drain;
    assign buf_wen_o    = drain;
    assign buf_addr_o   = drain ? addr_q : '0;
    assign buf_din_o    = drain ? act_q[lane_q] : '0;
    // An abort landing on the DONE cycle suppresses the completion pulse.
    assign frame_done_o = (state_q == DONE) && !start_i;

endmodule

// File: tb/tb_layer4_obuf_writer.sv
// Directed testbench for layer4_obuf_writer: frame, quantisation, backpressure,
// abort, mid-frame reset and start/valid collision scenarios.
module tb_layer4_obuf_writer;

    logic         clk = 1'b0;
    logic         rstn;
    logic         start;
    logic         acc_valid;
    logic         acc_ready;
    logic [127:0] acc_data;
    logic         buf_en;
    logic         buf_wen;
    logic [4:0]   buf_addr;
    logic [7:0]   buf_din;
    logic         frame_done;
    logic         busy;

    int total  = 0;
    int passed = 0;

    layer4_obuf_writer dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .start_i      (start),
        .acc_valid_i  (acc_valid),
        .acc_ready_o  (acc_ready),
        .acc_data_i   (acc_data),
        .buf_en_o     (buf_en),
        .buf_wen_o    (buf_wen),
        .buf_addr_o   (buf_addr),
        .buf_din_o    (buf_din),
        .frame_done_o (frame_done),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    // Cycle counter and write/handshake/done log, sampled on the falling edge.
    int         cyc = 0;
    logic [4:0] wr_addr [$];
    logic [7:0] wr_din  [$];
    int         wr_cyc  [$];
    int         hs_cyc  [$];
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         rdy_in_drain = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (buf_en && buf_wen) begin
            wr_addr.push_back(buf_addr);
            wr_din.push_back(buf_din);
            wr_cyc.push_back(cyc);
        end
        if (frame_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (rstn && acc_valid && acc_ready && !start) hs_cyc.push_back(cyc);
        if (acc_ready && buf_en) rdy_in_drain <= rdy_in_drain + 1;
    end

    // Lane l carries 128*(din0 + stride*l), which quantises to exactly that din.
    function automatic logic [127:0] bundle(input int din0, input int stride);
        logic [127:0] r;
        r = '0;
        for (int l = 0; l < 4; l++) r[l*32 +: 32] = 32'(128 * (din0 + stride * l));
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send_bundle(input logic [127:0] data, input bit keep);
        bit ok;
        bit hs;
        ok = 1'b0;
        acc_data  = data;
        acc_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            hs = acc_ready && !start;
            tick(1);
            ok = hs;
        end
        if (!keep) acc_valid = 1'b0;
        total++;
        if (!ok) $display("FAIL handshake: acc_ready_o=%b after 20 cycles, required 1", acc_ready);
        else passed++;
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 30) begin
            tick(1);
            n++;
        end
        total++;
        if (done_cnt == d0) $display("FAIL done_timeout: frame_done_o count=%0d, required %0d", done_cnt - d0, 1);
        else passed++;
    endtask

    task automatic check_frame(input int wb, input int din0, input int stride);
        total++;
        if (wr_addr.size() < wb + 32) $display("FAIL frame_writes: got %0d writes, required 32", wr_addr.size() - wb);
        else passed++;
        for (int i = 0; i < 32 && wb + i < wr_addr.size(); i++) begin
            total++;
            if ({wr_addr[wb+i], wr_din[wb+i]} !== {5'(i), 8'(din0 + stride * i)})
                $display("FAIL frame_write[%0d]: addr=%0d din=%0d, required addr=%0d din=%0d",
                         i, wr_addr[wb+i], wr_din[wb+i], i, din0 + stride * i);
            else passed++;
        end
    endtask

    task automatic test_reset;
        rstn = 1'b1; start = 1'b0; acc_valid = 1'b0; acc_data = '0;
        #2 rstn = 1'b0;
        #10;
        total++; if (acc_ready !== 1'b0)  $display("FAIL rst_ready: got %b, required 0", acc_ready);   else passed++;
        total++; if (buf_en !== 1'b0)     $display("FAIL rst_en: got %b, required 0", buf_en);         else passed++;
        total++; if (buf_wen !== 1'b0)    $display("FAIL rst_wen: got %b, required 0", buf_wen);       else passed++;
        total++; if (buf_addr !== 5'd0)   $display("FAIL rst_addr: got %0d, required 0", buf_addr);    else passed++;
        total++; if (buf_din !== 8'd0)    $display("FAIL rst_din: got %0d, required 0", buf_din);      else passed++;
        total++; if (frame_done !== 1'b0) $display("FAIL rst_done: got %b, required 0", frame_done);   else passed++;
        total++; if (busy !== 1'b0)       $display("FAIL rst_busy: got %b, required 0", busy);         else passed++;
        @(posedge clk); #1;
        rstn = 1'b1;
        tick(2);
        total++; if (busy !== 1'b0)       $display("FAIL idle_busy: got %b, required 0", busy);        else passed++;
    endtask

    task automatic test_normal_frame;
        int wb, hb, d0;
        wb = wr_addr.size(); hb = hs_cyc.size(); d0 = done_cnt;
        pulse_start;
        total++; if (acc_ready !== 1'b1) $display("FAIL accept_ready: got %b, required 1", acc_ready); else passed++;
        total++; if (busy !== 1'b1)      $display("FAIL accept_busy: got %b, required 1", busy);       else passed++;
        for (int b = 0; b < 8; b++) send_bundle(bundle(4 * b, 1), 1'b0);
        wait_done(d0);
        tick(3);
        check_frame(wb, 0, 1);
        total++; if (done_cnt - d0 !== 1) $display("FAIL normal_done_count: got %0d, required 1", done_cnt - d0); else passed++;
        if (wr_cyc.size() >= wb + 32) begin
            total++;
            if (done_cyc !== wr_cyc[wb+31] + 1)
                $display("FAIL done_latency: done at cycle %0d, required %0d", done_cyc, wr_cyc[wb+31] + 1);
            else passed++;
            total++;
            if (wr_cyc[wb] !== hs_cyc[hb] + 1)
                $display("FAIL write_latency: first write at cycle %0d, required %0d", wr_cyc[wb], hs_cyc[hb] + 1);
            else passed++;
        end
        total++; if (busy !== 1'b0) $display("FAIL post_done_busy: got %b, required 0", busy); else passed++;
    endtask

    task automatic test_quant;
        int wb;
        logic [7:0] exp_q [12];
`ifdef L4W_ROUND_EN
        exp_q = '{8'd0, 8'd1, 8'd127, 8'd127, 8'd1, 8'd2, 8'd127, 8'd127, 8'd0, 8'd2, 8'd0, 8'd127};
`else
        exp_q = '{8'd0, 8'd0, 8'd127, 8'd127, 8'd0, 8'd1, 8'd127, 8'd127, 8'd0, 8'd1, 8'd0, 8'd127};
`endif
        wb = wr_addr.size();
        pulse_start;
        send_bundle({32'd40000, 32'd16256, 32'd127, -32'sd5}, 1'b0);
        send_bundle({32'h7FFF_FFFF, 32'd16383, 32'd255, 32'd64}, 1'b0);
        send_bundle({32'd16384, 32'd0, 32'd200, 32'h8000_0000}, 1'b0);
        tick(4);
        total++;
        if (wr_addr.size() - wb !== 12) $display("FAIL quant_writes: got %0d, required 12", wr_addr.size() - wb);
        else passed++;
        for (int i = 0; i < 12 && wb + i < wr_addr.size(); i++) begin
            total++;
            if ({wr_addr[wb+i], wr_din[wb+i]} !== {5'(i), exp_q[i]})
                $display("FAIL quant[%0d]: addr=%0d din=%0d, required addr=%0d din=%0d",
                         i, wr_addr[wb+i], wr_din[wb+i], i, exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_backpressure;
        int wb, hb, d0, r0;
        wb = wr_addr.size(); hb = hs_cyc.size(); d0 = done_cnt; r0 = rdy_in_drain;
        pulse_start;
        for (int b = 0; b < 8; b++) send_bundle(bundle(31 - 4 * b, -1), 1'b1);
        wait_done(d0);
        tick(2);
        acc_valid = 1'b0;
        total++; if (hs_cyc.size() - hb !== 8) $display("FAIL bp_handshakes: got %0d, required 8", hs_cyc.size() - hb); else passed++;
        total++; if (rdy_in_drain !== r0) $display("FAIL bp_ready_in_drain: got %0d cycles, required 0", rdy_in_drain - r0); else passed++;
        check_frame(wb, 31, -1);
        if (wr_cyc.size() >= wb + 32) begin
            total++;
            if (wr_cyc[wb+31] - wr_cyc[wb] !== 38)
                $display("FAIL bp_throughput: span %0d cycles, required 38", wr_cyc[wb+31] - wr_cyc[wb]);
            else passed++;
        end
        total++; if (done_cnt - d0 !== 1) $display("FAIL bp_done_count: got %0d, required 1", done_cnt - d0); else passed++;
    endtask

    task automatic test_abort;
        int wb, d0;
        wb = wr_addr.size(); d0 = done_cnt;
        pulse_start;
        for (int b = 0; b < 5; b++) send_bundle(bundle(4 * b, 1), 1'b0);
        tick(2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int b = 0; b < 8; b++) send_bundle(bundle(12 * b, 3), 1'b0);
        wait_done(d0);
        tick(3);
        total++;
        if (wr_addr.size() - wb !== 51) $display("FAIL abort_writes: got %0d, required 51", wr_addr.size() - wb);
        else passed++;
        if (wr_addr.size() >= wb + 19) begin
            total++;
            if ({wr_addr[wb+18], wr_din[wb+18]} !== {5'd18, 8'd18})
                $display("FAIL abort_pending_write: addr=%0d din=%0d, required addr=18 din=18", wr_addr[wb+18], wr_din[wb+18]);
            else passed++;
        end
        check_frame(wb + 19, 0, 3);
        total++; if (done_cnt - d0 !== 1) $display("FAIL abort_done_count: got %0d, required 1", done_cnt - d0); else passed++;
    endtask

    task automatic test_reset_mid_drain;
        int wb, hb, d0;
        wb = wr_addr.size(); d0 = done_cnt;
        pulse_start;
        for (int b = 0; b < 4; b++) send_bundle(bundle(4 * b, 1), 1'b0);
        tick(1);
        total++; if (buf_addr !== 5'd13 || buf_en !== 1'b1) $display("FAIL pre_reset_addr: addr=%0d en=%b, required addr=13 en=1", buf_addr, buf_en); else passed++;
        rstn = 1'b0;
        #1;
        total++; if (buf_en !== 1'b0)     $display("FAIL mid_rst_en: got %b, required 0", buf_en);       else passed++;
        total++; if (buf_wen !== 1'b0)    $display("FAIL mid_rst_wen: got %b, required 0", buf_wen);     else passed++;
        total++; if (buf_addr !== 5'd0)   $display("FAIL mid_rst_addr: got %0d, required 0", buf_addr);  else passed++;
        total++; if (buf_din !== 8'd0)    $display("FAIL mid_rst_din: got %0d, required 0", buf_din);    else passed++;
        total++; if (acc_ready !== 1'b0)  $display("FAIL mid_rst_ready: got %b, required 0", acc_ready); else passed++;
        total++; if (busy !== 1'b0)       $display("FAIL mid_rst_busy: got %b, required 0", busy);       else passed++;
        total++; if (frame_done !== 1'b0) $display("FAIL mid_rst_done: got %b, required 0", frame_done); else passed++;
        hb = hs_cyc.size();
        @(posedge clk); #1;
        rstn = 1'b1;
        acc_valid = 1'b1;
        tick(5);
        total++; if (busy !== 1'b0)      $display("FAIL post_rst_busy: got %b, required 0", busy);       else passed++;
        total++; if (acc_ready !== 1'b0) $display("FAIL post_rst_ready: got %b, required 0", acc_ready); else passed++;
        total++; if (wr_addr.size() - wb !== 13) $display("FAIL post_rst_writes: got %0d, required 13", wr_addr.size() - wb); else passed++;
        total++; if (hs_cyc.size() !== hb) $display("FAIL post_rst_handshake: got %0d, required 0", hs_cyc.size() - hb); else passed++;
        total++; if (done_cnt !== d0)    $display("FAIL post_rst_done: got %0d, required 0", done_cnt - d0); else passed++;
        acc_valid = 1'b0;
    endtask

    task automatic test_collision;
        int wb, ccyc;
        pulse_start;
        send_bundle(bundle(10, 1), 1'b0);
        tick(4);
        wb = wr_addr.size();
        start     = 1'b1;
        acc_valid = 1'b1;
        acc_data  = bundle(20, 1);
        @(negedge clk);
        ccyc = cyc;
        total++; if (acc_ready !== 1'b1) $display("FAIL collision_ready: got %b, required 1", acc_ready); else passed++;
        @(posedge clk); #1;
        start = 1'b0;
        tick(1);
        acc_valid = 1'b0;
        tick(5);
        total++;
        if (wr_addr.size() - wb !== 4) $display("FAIL collision_writes: got %0d, required 4", wr_addr.size() - wb);
        else passed++;
        if (wr_addr.size() >= wb + 4) begin
            total++;
            if ({wr_addr[wb], wr_din[wb]} !== {5'd0, 8'd20})
                $display("FAIL collision_first: addr=%0d din=%0d, required addr=0 din=20", wr_addr[wb], wr_din[wb]);
            else passed++;
            total++;
            if (wr_cyc[wb] !== ccyc + 2)
                $display("FAIL collision_latency: first write at cycle %0d, required %0d", wr_cyc[wb], ccyc + 2);
            else passed++;
            total++;
            if ({wr_addr[wb+3], wr_din[wb+3]} !== {5'd3, 8'd23})
                $display("FAIL collision_last: addr=%0d din=%0d, required addr=3 din=23", wr_addr[wb+3], wr_din[wb+3]);
            else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_normal_frame;
        test_quant;
        test_backpressure;
        test_abort;
        test_reset_mid_drain;
        test_collision;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", passed, total);
        $fatal(1, "watchdog expired");
    end

endmodule
